// File: rtl/seqdect_pkg.sv
// Shared types and constants for the serial pattern-detect frame controller.
package seqdect_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned ByteW          = 8;
  localparam logic [5:0]  DefaultPattern = 6'b101010;

endpackage

// File: rtl/bit_pattern_match.sv
// Overlapping serial pattern matcher; match pulses the cycle after the completing bit.
module bit_pattern_match #(
  parameter int unsigned PAT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);

  logic [PAT_W-2:0] hist_q;
  logic [FillW-1:0] fill_q;
  logic             match_q;
  logic [PAT_W-1:0] window;
  logic             primed;

  assign window = {hist_q, bit_in};
  // The incoming bit itself completes the PAT_W-bit window once PAT_W-1 bits are held.
  assign primed = (fill_q >= FillW'(PAT_W - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      match_q <= 1'b0;
      if (bit_valid) begin
        hist_q  <= window[PAT_W-2:0];
        match_q <= primed && (window == pattern);
        if (fill_q != FillW'(PAT_W)) begin
          fill_q <= fill_q + 1'b1;
        end
      end
    end
  end

  assign match = match_q;

endmodule

// File: rtl/seqdect_ctrl.sv
// Frame controller: accepts bytes, serializes MSB-first into the matcher, counts matches.
module seqdect_ctrl #(
  parameter int unsigned PAT_W = 6,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             hit,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic             overflow
);

  import seqdect_pkg::*;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [ByteW-1:0] byte_q, byte_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [LEN_W-1:0] bits_done_q, bits_done_d;
  logic [LEN_W-1:0] bits_done_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             clr;
  logic             bit_valid;

  assign bits_done_inc = bits_done_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    byte_d      = byte_q;
    bit_idx_d   = bit_idx_q;
    bits_done_d = bits_done_q;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    clr         = 1'b0;
    bit_valid   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pat_d       = cfg_pattern;
          len_d       = frame_len;
          bits_done_d = '0;
          clr         = 1'b1;
          state_d     = (frame_len == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          byte_d    = in_data;
          bit_idx_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        busy        = 1'b1;
        bit_valid   = 1'b1;
        byte_d      = {byte_q[ByteW-2:0], 1'b0};
        bit_idx_d   = bit_idx_q + 1'b1;
        bits_done_d = bits_done_inc;
        // Frame end wins over byte end; leftover bits of a partial byte are dropped.
        if (bits_done_inc == len_q) begin
          state_d = StDone;
        end else if (bit_idx_q == 3'd7) begin
          state_d = StLoad;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  bit_pattern_match #(
    .PAT_W(PAT_W)
  ) u_match (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .bit_valid(bit_valid),
    .bit_in   (byte_q[ByteW-1]),
    .pattern  (pat_q),
    .match    (hit)
  );

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (hit) begin
      if (cnt_q == CntMax) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Fold the pending hit in so the count is visible in the same cycle as the pulse.
  assign match_cnt = (hit && (cnt_q != CntMax)) ? cnt_q + 1'b1 : cnt_q;
  assign overflow  = ovf_q | (hit && (cnt_q == CntMax));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pat_q       <= PAT_W'(DefaultPattern);
      len_q       <= '0;
      byte_q      <= '0;
      bit_idx_q   <= '0;
      bits_done_q <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      byte_q      <= byte_d;
      bit_idx_q   <= bit_idx_d;
      bits_done_q <= bits_done_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_seqdect_ctrl.sv
// Bench for seqdect_ctrl: two instances (8-bit and 2-bit counters) share all stimulus.
module tb_seqdect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  cfg_pattern = '0;
  logic        start = 1'b0;
  logic [11:0] frame_len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;

  logic        in_ready, busy, hit, done, overflow;
  logic [7:0]  match_cnt;
  logic        in_ready2, busy2, hit2, done2, overflow2;
  logic [1:0]  match_cnt2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hit_log[$];
  int hit2_tot = 0;
  logic [7:0] bytes_a [8];
  int stall_a [8];

  seqdect_ctrl dut (
    .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy), .hit(hit),
    .done(done), .match_cnt(match_cnt), .overflow(overflow)
  );

  seqdect_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2), .busy(busy2), .hit(hit2),
    .done(done2), .match_cnt(match_cnt2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (hit) hit_log.push_back(cyc);
    if (hit2) hit2_tot <= hit2_tot + 1;
  end

  task automatic set_stalls(input int v);
    for (int i = 0; i < 8; i++) stall_a[i] = v;
  endtask

  // Runs one frame; expected matches come from a sliding-window scan of the bit list.
  task automatic run_frame(input string name, input logic [5:0] pat, input logic [11:0] len,
                           input bit noise);
    int base, h2base, rem, nb, m, ecnt1, ecnt2, got;
    bit eovf1, eovf2, ok;
    int bits[$];
    int pcyc[$];
    int exp_q[$];
    base   = hit_log.size();
    h2base = hit2_tot;
    @(negedge clk);
    start = 1'b1; cfg_pattern = pat; frame_len = len;
    @(negedge clk);
    start = 1'b0;
    rem = int'(len);
    for (int b = 0; rem > 0; b++) begin
      for (int s = 0; s <= stall_a[b]; s++) begin
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
          fails++;
          $display("FAIL %s load: in_ready=%b busy=%b want 1 1", name, in_ready, busy);
        end
        if (s < stall_a[b]) @(negedge clk);
      end
      in_valid = 1'b1; in_data = bytes_a[b];
      @(negedge clk);
      in_valid = 1'b0; in_data = 8'($urandom);
      nb = (rem > 8) ? 8 : rem;
      for (int j = 0; j < nb; j++) begin
        tests++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
          fails++;
          $display("FAIL %s shift: busy=%b in_ready=%b done=%b want 1 0 0",
                   name, busy, in_ready, done);
        end
        bits.push_back(int'(bytes_a[b][7-j]));
        pcyc.push_back(cyc);
        if (noise) begin
          start = 1'($urandom); cfg_pattern = 6'($urandom);
          frame_len = 12'($urandom); in_valid = 1'($urandom);
        end
        @(negedge clk);
      end
      start = 1'b0; in_valid = 1'b0;
      rem -= nb;
    end
    m = 0;
    for (int i = 5; i < bits.size(); i++) begin
      int v;
      v = 0;
      for (int k = 0; k < 6; k++) v = v * 2 + bits[i-5+k];
      if (v == int'(pat)) begin
        m++;
        exp_q.push_back(pcyc[i] + 1);
      end
    end
    ecnt1 = (m > 255) ? 255 : m; eovf1 = (m > 255);
    ecnt2 = (m > 3) ? 3 : m;     eovf2 = (m > 3);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || done2 !== 1'b1) begin
      fails++;
      $display("FAIL %s done: done=%b busy=%b in_ready=%b done2=%b want 1 0 0 1",
               name, done, busy, in_ready, done2);
    end
    tests++;
    if (match_cnt !== 8'(ecnt1) || overflow !== eovf1) begin
      fails++;
      $display("FAIL %s count: cnt=%0d ovf=%b want %0d %b", name, match_cnt, overflow,
               ecnt1, eovf1);
    end
    tests++;
    if (match_cnt2 !== 2'(ecnt2) || overflow2 !== eovf2) begin
      fails++;
      $display("FAIL %s count2: cnt=%0d ovf=%b want %0d %b", name, match_cnt2, overflow2,
               ecnt2, eovf2);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || match_cnt !== 8'(ecnt1) || overflow !== eovf1 ||
        match_cnt2 !== 2'(ecnt2) || overflow2 !== eovf2) begin
      fails++;
      $display("FAIL %s hold: done=%b busy=%b cnt=%0d cnt2=%0d want 0 0 %0d %0d",
               name, done, busy, match_cnt, match_cnt2, ecnt1, ecnt2);
    end
    got = hit_log.size() - base;
    ok  = (got == exp_q.size());
    if (ok) begin
      for (int k = 0; k < exp_q.size(); k++) if (hit_log[base+k] != exp_q[k]) ok = 1'b0;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s hit_timing: got %0d pulses want %0d (first got %0d want %0d)", name,
               got, exp_q.size(), (got > 0) ? hit_log[base] : -1,
               (exp_q.size() > 0) ? exp_q[0] : -1);
    end
    tests++;
    if (hit2_tot - h2base != m) begin
      fails++;
      $display("FAIL %s hit2_count: got %0d want %0d", name, hit2_tot - h2base, m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || hit !== 1'b0 || done !== 1'b0 ||
        overflow !== 1'b0 || match_cnt !== 8'd0 || match_cnt2 !== 2'd0 || busy2 !== 1'b0) begin
      fails++;
      $display("FAIL reset: rdy=%b busy=%b hit=%b done=%b ovf=%b cnt=%0d want all 0",
               in_ready, busy, hit, done, overflow, match_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b rdy=%b done=%b want 0 0 0", busy, in_ready, done);
    end
  endtask

  task automatic test_single_byte();
    set_stalls(0);
    bytes_a[0] = 8'hAA;
    run_frame("aa_len8", 6'b101010, 12'd8, 1'b0);
  endtask

  task automatic test_stall();
    set_stalls(0);
    stall_a[1] = 3;
    bytes_a[0] = 8'hAA; bytes_a[1] = 8'hAA;
    run_frame("stall_len16", 6'b101010, 12'd16, 1'b0);
  endtask

  task automatic test_partial_byte();
    set_stalls(0);
    bytes_a[0] = 8'hA0;
    run_frame("partial_len4", 6'b101010, 12'd4, 1'b0);
    bytes_a[0] = 8'hA8;
    run_frame("fresh_len6", 6'b101010, 12'd6, 1'b0);
  endtask

  task automatic test_saturate();
    set_stalls(0);
    bytes_a[0] = 8'h00; bytes_a[1] = 8'h00;
    run_frame("saturate", 6'b000000, 12'd16, 1'b0);
  endtask

  task automatic test_zero_len();
    set_stalls(0);
    run_frame("zero_len", 6'b101010, 12'd0, 1'b0);
  endtask

  task automatic test_start_ignored();
    set_stalls(1);
    bytes_a[0] = 8'hAA; bytes_a[1] = 8'hAA;
    run_frame("start_busy", 6'b101010, 12'd16, 1'b1);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1; cfg_pattern = 6'b101010; frame_len = 12'd16;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_busy: busy=%b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || hit !== 1'b0 || done !== 1'b0 ||
        overflow !== 1'b0 || match_cnt !== 8'd0 || done2 !== 1'b0 || match_cnt2 !== 2'd0) begin
      fails++;
      $display("FAIL mid_reset: rdy=%b busy=%b hit=%b done=%b ovf=%b cnt=%0d want all 0",
               in_ready, busy, hit, done, overflow, match_cnt);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL mid_reset_quiet: done=%b busy=%b rdy=%b want 0 0 0",
                 done, busy, in_ready);
      end
    end
    set_stalls(0);
    bytes_a[0] = 8'hAA;
    run_frame("after_rst", 6'b101010, 12'd8, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] pick [5];
    pick[0] = 8'hAA; pick[1] = 8'h55; pick[2] = 8'h00; pick[3] = 8'hFF; pick[4] = 8'h00;
    for (int it = 0; it < 30; it++) begin
      logic [5:0]  pat;
      logic [11:0] len;
      pat = 6'($urandom);
      len = 12'($urandom_range(0, 40));
      for (int b = 0; b < 8; b++) begin
        bytes_a[b] = ($urandom_range(0, 1) == 0) ? 8'($urandom) : pick[$urandom_range(0, 3)];
        stall_a[b] = $urandom_range(0, 3);
      end
      run_frame($sformatf("rnd%0d", it), pat, len, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_stall();
    test_partial_byte();
    test_saturate();
    test_zero_len();
    test_start_ignored();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seqdect_ctrl.md
# seqdect_ctrl

Frame controller for serial pattern detection. Accepts parallel bytes over a valid/ready handshake and serializes them MSB-first at one bit per clock into a programmable overlapping pattern matcher. For each frame it counts matches over a programmed number of bits, then reports the count with a done pulse. It sits between a byte-wide producer and the status/interrupt logic that consumes match counts.

## Interface
- PAT_W, 6: pattern length in bits (2..16)
- CNT_W, 8: match counter width
- LEN_W, 12: frame length field width, in bits
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_pattern  in  PAT_W  pattern; MSB is the first bit expected; sampled on start acceptance
- start  in  1  frame start request; accepted only in IDLE
- frame_len  in  LEN_W  frame length in bits; sampled with start
- in_valid  in  1  byte available
- in_data  in  8  byte, serialized bit 7 first
- in_ready  out  1  controller accepts a byte this cycle
- busy  out  1  frame in progress (LOAD or SHIFT)
- hit  out  1  one-cycle pulse per detected match
- done  out  1  one-cycle pulse at frame end
- match_cnt  out  CNT_W  matches in current/last frame, saturating
- overflow  out  1  sticky per frame: a hit occurred while match_cnt was saturated

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: start=1 latches cfg_pattern and frame_len, clears match_cnt, overflow, history and bit counters.
  - frame_len==0 → DONE.
  - Otherwise → LOAD.
- LOAD: in_ready=1. On in_valid, latch the byte → SHIFT.
- SHIFT: each cycle, shift one byte bit (bit 7 first) into the history and increment bits_done.
  - Stop when 8 bits are consumed or bits_done reaches frame_len.
  - If bits_done==frame_len → DONE. Unused low bits of a partial last byte are discarded.
  - Otherwise → LOAD.
- DONE: done=1 for one cycle → IDLE.
- Match rule: {history[PAT_W-2:0], bit} == pattern, and at least PAT_W bits have been consumed in this frame.
  - Matches overlap: the history is not cleared on a hit.
  - Matches never span frames.
- Counter rule:
  - Each match increments match_cnt, saturating at 2^CNT_W-1.
  - A match while saturated sets overflow.
  - match_cnt and overflow hold after done until the next accepted start.
- start is ignored outside IDLE. in_valid is ignored outside LOAD.

## Timing
- Reset: state=IDLE. in_ready, busy, hit, done, overflow = 0. match_cnt = 0. History and counters are cleared.
- rst mid-frame aborts immediately: no done pulse, and any held byte is dropped.
- start accepted in cycle T: busy=1 and in_ready=1 from T+1 (LOAD).
- Byte handshake in cycle L: bits are processed in cycles L+1..L+8, or fewer for the last byte. The next LOAD is at L+9, so peak throughput is 1 byte per 9 cycles.
- Bit processed in cycle N completes a match: hit=1 in N+1, and match_cnt shows the incremented value from N+1.
- Last frame bit processed in cycle N: DONE in N+1. done=1, busy=0, and any hit from bit N is asserted in the same cycle. match_cnt is final in N+1.
- frame_len==0 with start at T: done=1 at T+1. in_ready is never asserted.
- done and start cannot overlap, because start is only accepted in IDLE. The earliest new start is in the cycle after done.

## Structure
- Package seqdect_pkg holds:
  - state enum (IDLE/LOAD/SHIFT/DONE), 2-bit encoding;
  - default pattern constant 6'b101010;
  - byte width constant 8.
- Sub-module bit_pattern_match (parameter PAT_W):
  - inputs: clk, rst, clr, bit_valid, bit_in, pattern;
  - internals: PAT_W-1-bit history and a fill counter saturating at PAT_W;
  - output: registered match pulse.
- The controller owns the FSM, byte shift register, bit counters and saturating counter.

## Test plan
- Pattern 6'b101010, frame_len=8, byte 0xAA → hits after bits 6 and 8, done with match_cnt=2, overflow=0.
- Pattern 6'b101010, frame_len=16, bytes 0xAA,0xAA, with in_valid stalled 3 cycles before byte 2 → in_ready held through the stall, match_cnt=6, done 1 cycle after the last bit.
- frame_len=4, byte 0xA0 → no hit, done after 4 SHIFT cycles, match_cnt=0. Then a new frame with frame_len=6, byte 0xA8 → match_cnt=1, no match from stale history.
- CNT_W=2, pattern 6'b000000, frame_len=16, bytes 0x00,0x00 → 11 hit pulses, match_cnt=3, overflow=1.
- frame_len=0 → done at T+1, in_ready never high, match_cnt=0. start asserted during busy → ignored, counts unaffected.
- rst asserted in the 4th SHIFT cycle → next cycle: IDLE, all outputs 0, no done. A following start runs a clean frame.
